vgatiming_gen: RTL and testbench

- Parametrised successor to the fixed 11-bit VGA timing generator.
- Produces hSync, vSync and data-enable, pixel X/Y coordinates and line/frame interrupts from programmable horizontal/vertical timing.
- Adds a pixel-clock enable, double-buffered timing registers applied only at frame boundary, and a configurable output pipeline delay to align with downstream pixel fetch.
- Sits between the register file (timing inputs) and the pixel/DAC pipeline.

---
 rtl/vgatiming_gen.sv | 248 ++++++++++++++++++++++++
 tb/tb_vgatiming_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vgatiming_gen.sv
// vgatiming_gen: programmable VGA timing generator.
// Generates hSync/vSync/data-enable, pixel X/Y coordinates and line/frame
// interrupts from a shadowed timing set that is applied only at frame wrap.
// Counters and the output pipeline advance only while i_pixen is high.
// PIPE adds registered delay stages on the sync/de/coordinate outputs.
// Optional line-compare interrupt (o_intline): define VGATIMING_LINECMP_EN.
module vgatiming_gen #(
   parameter int CW   = 12,
   parameter int PIPE = 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_pixen,
   input  logic [CW-1:0] i_hSyncStart,
   input  logic [CW-1:0] i_hBpStart,
   input  logic [CW-1:0] i_hVisibleStart,
   input  logic [CW-1:0] i_hEnd,
   input  logic          i_hSyncPol,
   input  logic [CW-1:0] i_vSyncStart,
   input  logic [CW-1:0] i_vBpStart,
   input  logic [CW-1:0] i_vVisibleStart,
   input  logic [CW-1:0] i_vEnd,
   input  logic          i_vSyncPol,
   input  logic          i_load,
   input  logic [CW-1:0] i_lineCmp,
   output logic          o_hSync,
   output logic          o_vSync,
   output logic          o_de,
   output logic [CW-1:0] o_x,
   output logic [CW-1:0] o_y,
   output logic          o_inth,
   output logic          o_intv,
   output logic          o_intline,
   output logic          o_loadPending
);

   localparam logic [CW-1:0] ALL_ONES = {CW{1'b1}};

   // ------------------------------------------------------------------
   // Active timing set
   // ------------------------------------------------------------------
   logic [CW-1:0] h_sync_start_q, h_sync_start_d;
   logic [CW-1:0] h_bp_start_q,   h_bp_start_d;
   logic [CW-1:0] h_vis_start_q,  h_vis_start_d;
   logic [CW-1:0] h_end_q,        h_end_d;
   logic          h_pol_q,        h_pol_d;
   logic [CW-1:0] v_sync_start_q, v_sync_start_d;
   logic [CW-1:0] v_bp_start_q,   v_bp_start_d;
   logic [CW-1:0] v_vis_start_q,  v_vis_start_d;
   logic [CW-1:0] v_end_q,        v_end_d;
   logic          v_pol_q,        v_pol_d;

   // ------------------------------------------------------------------
   // Counters, wrap detection and load handshake
   // ------------------------------------------------------------------
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] vcnt_q, vcnt_d;
   logic [CW-1:0] vcnt_next;
   logic          load_pending_q, load_pending_d;
   logic          h_wrap;
   logic          v_wrap;
   logic          line_wrap;
   logic          frame_wrap;
   logic          apply_load;

   // Wrap conditions: programmed end or all-ones, so bad timing cannot lock up
   always_comb begin
      h_wrap     = (hcnt_q == h_end_q) || (hcnt_q == ALL_ONES);
      v_wrap     = (vcnt_q == v_end_q) || (vcnt_q == ALL_ONES);
      line_wrap  = i_pixen && h_wrap;
      frame_wrap = line_wrap && v_wrap;
      apply_load = frame_wrap && (load_pending_q || i_load);
      vcnt_next  = v_wrap ? '0 : vcnt_q + CW'(1);
   end

   // Next-state for the pixel and line counters
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (i_pixen) begin
         hcnt_d = h_wrap ? '0 : hcnt_q + CW'(1);
      end
      if (line_wrap) begin
         vcnt_d = vcnt_next;
      end
   end

   // Pending flag: set by a load request, cleared by the frame wrap that
   // consumes it; a request arriving on the wrap cycle is applied at once
   always_comb begin
      load_pending_d = load_pending_q || i_load;
      if (frame_wrap) begin
         load_pending_d = 1'b0;
      end
   end

   // Shadow-to-active transfer only at a frame wrap with a load outstanding
   always_comb begin
      h_sync_start_d = h_sync_start_q;
      h_bp_start_d   = h_bp_start_q;
      h_vis_start_d  = h_vis_start_q;
      h_end_d        = h_end_q;
      h_pol_d        = h_pol_q;
      v_sync_start_d = v_sync_start_q;
      v_bp_start_d   = v_bp_start_q;
      v_vis_start_d  = v_vis_start_q;
      v_end_d        = v_end_q;
      v_pol_d        = v_pol_q;
      if (apply_load) begin
         h_sync_start_d = i_hSyncStart;
         h_bp_start_d   = i_hBpStart;
         h_vis_start_d  = i_hVisibleStart;
         h_end_d        = i_hEnd;
         h_pol_d        = i_hSyncPol;
         v_sync_start_d = i_vSyncStart;
         v_bp_start_d   = i_vBpStart;
         v_vis_start_d  = i_vVisibleStart;
         v_end_d        = i_vEnd;
         v_pol_d        = i_vSyncPol;
      end
   end

   // Timing, counter and handshake registers; reset takes the live inputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         h_sync_start_q <= i_hSyncStart;
         h_bp_start_q   <= i_hBpStart;
         h_vis_start_q  <= i_hVisibleStart;
         h_end_q        <= i_hEnd;
         h_pol_q        <= i_hSyncPol;
         v_sync_start_q <= i_vSyncStart;
         v_bp_start_q   <= i_vBpStart;
         v_vis_start_q  <= i_vVisibleStart;
         v_end_q        <= i_vEnd;
         v_pol_q        <= i_vSyncPol;
         hcnt_q         <= '0;
         vcnt_q         <= '0;
         load_pending_q <= 1'b0;
      end else begin
         h_sync_start_q <= h_sync_start_d;
         h_bp_start_q   <= h_bp_start_d;
         h_vis_start_q  <= h_vis_start_d;
         h_end_q        <= h_end_d;
         h_pol_q        <= h_pol_d;
         v_sync_start_q <= v_sync_start_d;
         v_bp_start_q   <= v_bp_start_d;
         v_vis_start_q  <= v_vis_start_d;
         v_end_q        <= v_end_d;
         v_pol_q        <= v_pol_d;
         hcnt_q         <= hcnt_d;
         vcnt_q         <= vcnt_d;
         load_pending_q <= load_pending_d;
      end
   end

   // ------------------------------------------------------------------
   // Region decode on the current counter values
   // ------------------------------------------------------------------
   logic          h_sync_act;
   logic          h_vis;
   logic          v_sync_act;
   logic          v_vis;
   logic          dec_hs;
   logic          dec_vs;
   logic          dec_de;
   logic [CW-1:0] dec_x;
   logic [CW-1:0] dec_y;

   // Sync/visible windows and coordinates relative to the visible origin
   always_comb begin
      h_sync_act = (hcnt_q >= h_sync_start_q) && (hcnt_q < h_bp_start_q);
      h_vis      = (hcnt_q >= h_vis_start_q) && (hcnt_q <= h_end_q);
      v_sync_act = (vcnt_q >= v_sync_start_q) && (vcnt_q < v_bp_start_q);
      v_vis      = (vcnt_q >= v_vis_start_q) && (vcnt_q <= v_end_q);
      dec_hs     = h_sync_act ? h_pol_q : ~h_pol_q;
      dec_vs     = v_sync_act ? v_pol_q : ~v_pol_q;
      dec_de     = h_vis && v_vis;
      dec_x      = dec_de ? (hcnt_q - h_vis_start_q) : '0;
      dec_y      = v_vis ? (vcnt_q - v_vis_start_q) : '0;
   end

   // ------------------------------------------------------------------
   // Output pipeline: stage 0 registers the decode, stages 1..PIPE delay it
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi <= PIPE; gi++) begin : g_stage
         logic          hs_d, vs_d, de_d;
         logic [CW-1:0] x_d, y_d;
         logic          hs_q, vs_q, de_q;
         logic [CW-1:0] x_q, y_q;

         if (gi == 0) begin : g_src
            assign hs_d = dec_hs;
            assign vs_d = dec_vs;
            assign de_d = dec_de;
            assign x_d  = dec_x;
            assign y_d  = dec_y;
         end else begin : g_src
            assign hs_d = g_stage[gi-1].hs_q;
            assign vs_d = g_stage[gi-1].vs_q;
            assign de_d = g_stage[gi-1].de_q;
            assign x_d  = g_stage[gi-1].x_q;
            assign y_d  = g_stage[gi-1].y_q;
         end

         // One delay stage advancing on enabled pixels; reset flushes to idle
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               hs_q <= ~i_hSyncPol;
               vs_q <= ~i_vSyncPol;
               de_q <= 1'b0;
               x_q  <= '0;
               y_q  <= '0;
            end else if (i_pixen) begin
               hs_q <= hs_d;
               vs_q <= vs_d;
               de_q <= de_d;
               x_q  <= x_d;
               y_q  <= y_d;
            end
         end
      end
   endgenerate

   assign o_hSync       = g_stage[PIPE].hs_q;
   assign o_vSync       = g_stage[PIPE].vs_q;
   assign o_de          = g_stage[PIPE].de_q;
   assign o_x           = g_stage[PIPE].x_q;
   assign o_y           = g_stage[PIPE].y_q;
   assign o_loadPending = load_pending_q;

   // ------------------------------------------------------------------
   // Interrupts: undelayed, one clock wide, on the enabled wrap cycle
   // ------------------------------------------------------------------
   assign o_inth = line_wrap && !i_reset;
   assign o_intv = frame_wrap && !i_reset;

`ifdef VGATIMING_LINECMP_EN
   // Fires on the wrap into the line that matches the live compare value
   assign o_intline = line_wrap && !i_reset && (vcnt_next == i_lineCmp);
`else
   logic unused_linecmp;
   assign unused_linecmp = ^i_lineCmp;
   assign o_intline      = 1'b0;
`endif

endmodule

// File: tb/tb_vgatiming_gen.sv
// tb_vgatiming_gen: randomized self-checking bench for vgatiming_gen.
// Two instances (PIPE=0 and PIPE=3) share stimulus; a behavioural model
// tracks beam position, shadow timing and a history of decoded pixels.
module tb_vgatiming_gen;
   localparam int CW   = 12;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, pixen, load, hpol, vpol;
   logic [CW-1:0] hss, hbp, hvs, hend, vss, vbp, vvs, vend, lcmp;

   logic          hs0, vs0, de0, inth0, intv0, intl0, lp0;
   logic [CW-1:0] x0, y0;
   logic          hs3, vs3, de3, inth3, intv3, intl3, lp3;
   logic [CW-1:0] x3, y3;

   vgatiming_gen #(.CW(CW), .PIPE(0)) u_dut0 (
      .i_clk(clk), .i_reset(rst), .i_pixen(pixen),
      .i_hSyncStart(hss), .i_hBpStart(hbp), .i_hVisibleStart(hvs), .i_hEnd(hend),
      .i_hSyncPol(hpol),
      .i_vSyncStart(vss), .i_vBpStart(vbp), .i_vVisibleStart(vvs), .i_vEnd(vend),
      .i_vSyncPol(vpol),
      .i_load(load), .i_lineCmp(lcmp),
      .o_hSync(hs0), .o_vSync(vs0), .o_de(de0), .o_x(x0), .o_y(y0),
      .o_inth(inth0), .o_intv(intv0), .o_intline(intl0), .o_loadPending(lp0)
   );

   vgatiming_gen #(.CW(CW), .PIPE(3)) u_dut3 (
      .i_clk(clk), .i_reset(rst), .i_pixen(pixen),
      .i_hSyncStart(hss), .i_hBpStart(hbp), .i_hVisibleStart(hvs), .i_hEnd(hend),
      .i_hSyncPol(hpol),
      .i_vSyncStart(vss), .i_vBpStart(vbp), .i_vVisibleStart(vvs), .i_vEnd(vend),
      .i_vSyncPol(vpol),
      .i_load(load), .i_lineCmp(lcmp),
      .o_hSync(hs3), .o_vSync(vs3), .o_de(de3), .o_x(x3), .o_y(y3),
      .o_inth(inth3), .o_intv(intv3), .o_intline(intl3), .o_loadPending(lp3)
   );

   typedef struct {
      int hss, hbp, hvs, hend, vss, vbp, vvs, vend;
      bit hpol, vpol;
   } tim_t;

   typedef struct {
      bit hs, vs, de;
      int x, y;
   } pix_t;

   tim_t act;
   int   mh = 0;
   int   mv = 0;
   bit   mpend = 1'b0;
   bit   armed = 1'b0;
   pix_t hist[$];
   pix_t rst_pix;
   int   total = 0;
   int   bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask

   function automatic tim_t cur_inputs();
      tim_t t;
      t.hss = int'(hss); t.hbp = int'(hbp); t.hvs = int'(hvs); t.hend = int'(hend);
      t.vss = int'(vss); t.vbp = int'(vbp); t.vvs = int'(vvs); t.vend = int'(vend);
      t.hpol = hpol; t.vpol = vpol;
      return t;
   endfunction

   // What the screen should show for beam position (h, v) under timing t
   function automatic pix_t decode(input int h, input int v, input tim_t t);
      pix_t p;
      bit hvis, vvis;
      hvis = (h >= t.hvs) && (h <= t.hend);
      vvis = (v >= t.vvs) && (v <= t.vend);
      p.hs = ((h >= t.hss) && (h < t.hbp)) ? t.hpol : !t.hpol;
      p.vs = ((v >= t.vss) && (v < t.vbp)) ? t.vpol : !t.vpol;
      p.de = hvis && vvis;
      p.x  = p.de ? ((h - t.hvs) & MAXC) : 0;
      p.y  = vvis ? ((v - t.vvs) & MAXC) : 0;
      return p;
   endfunction

   // Decode seen 'lat' enabled pixels ago, or the idle picture after reset
   function automatic pix_t expected(input int lat);
      if (hist.size() >= lat) return hist[hist.size() - lat];
      return rst_pix;
   endfunction

   // Check the outputs for this cycle, then advance the model past the edge
   task automatic step();
      bit   hw, vw, lw, fw, exp_il;
      int   nv;
      pix_t e0, e3;
      #1;
      hw = (mh == act.hend) || (mh == MAXC);
      vw = (mv == act.vend) || (mv == MAXC);
      lw = pixen && !rst && hw;
      fw = lw && vw;
      nv = vw ? 0 : mv + 1;
`ifdef VGATIMING_LINECMP_EN
      exp_il = lw && (nv == int'(lcmp));
`else
      exp_il = 1'b0;
`endif
      if (armed) begin
         e0 = expected(1);
         e3 = expected(4);
         check_val("hsync0", 32'(hs0), 32'(e0.hs));
         check_val("vsync0", 32'(vs0), 32'(e0.vs));
         check_val("de0",    32'(de0), 32'(e0.de));
         check_val("x0",     32'(x0),  32'(e0.x));
         check_val("y0",     32'(y0),  32'(e0.y));
         check_val("inth0",  32'(inth0), 32'(lw));
         check_val("intv0",  32'(intv0), 32'(fw));
         check_val("intline0", 32'(intl0), 32'(exp_il));
         check_val("pending0", 32'(lp0), 32'(mpend));
         check_val("hsync3", 32'(hs3), 32'(e3.hs));
         check_val("vsync3", 32'(vs3), 32'(e3.vs));
         check_val("de3",    32'(de3), 32'(e3.de));
         check_val("x3",     32'(x3),  32'(e3.x));
         check_val("y3",     32'(y3),  32'(e3.y));
         check_val("inth3",  32'(inth3), 32'(lw));
         check_val("intv3",  32'(intv3), 32'(fw));
         check_val("pending3", 32'(lp3), 32'(mpend));
      end
      if (rst) begin
         mh = 0;
         mv = 0;
         act = cur_inputs();
         mpend = 1'b0;
         hist.delete();
         rst_pix.hs = !hpol;
         rst_pix.vs = !vpol;
         rst_pix.de = 1'b0;
         rst_pix.x  = 0;
         rst_pix.y  = 0;
         armed = 1'b1;
      end else begin
         if (pixen) begin
            hist.push_back(decode(mh, mv, act));
            if (hist.size() > 8) void'(hist.pop_front());
            mh = hw ? 0 : mh + 1;
            if (hw) mv = nv;
            if (fw && (mpend || load)) act = cur_inputs();
         end
         mpend = fw ? 1'b0 : (mpend || load);
      end
   endtask

   task automatic cyc(input bit r, input bit pe, input bit ld);
      @(negedge clk);
      rst = r;
      pixen = pe;
      load = ld;
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_timing(input int a, input int b, input int c, input int d,
                             input int e, input int f, input int g, input int h);
      hss = CW'(a); hbp = CW'(b); hvs = CW'(c); hend = CW'(d);
      vss = CW'(e); vbp = CW'(f); vvs = CW'(g); vend = CW'(h);
   endtask

   task automatic rand_timing();
      int he, ve, s;
      he = int'($urandom_range(24, 6));
      ve = int'($urandom_range(12, 3));
      s  = int'($urandom_range(he, 0));
      set_timing(s, int'($urandom_range(he + 2, s)), int'($urandom_range(he + 2, 0)), he,
                 0, 0, 0, ve);
      s  = int'($urandom_range(ve, 0));
      vss = CW'(s);
      vbp = CW'($urandom_range(ve + 1, s));
      vvs = CW'($urandom_range(ve + 1, 0));
      hpol = 1'($urandom_range(1, 0));
      vpol = 1'($urandom_range(1, 0));
   endtask

   initial begin
      bit found;
      rst = 1'b1; pixen = 1'b1; load = 1'b0;
      hpol = 1'b0; vpol = 1'b0; lcmp = CW'(6);
      set_timing(4, 6, 8, 15, 2, 3, 4, 9);

      // basic frame with continuous pixel enable
      cyc(1, 1, 0);
      for (int i = 0; i < 400; i++) cyc(0, 1, 0);

      // pixel enable every second clock
      for (int i = 0; i < 400; i++) cyc(0, (i % 2) == 0, 0);

      // mid-frame timing change, applied at the next frame wrap
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (mv == 5 && mh == 0) found = 1'b1;
         else cyc(0, 1, 0);
      end
      if (!found) check_val("reach_line5", 32'(0), 32'(1));
      hend = CW'(19);
      cyc(0, 1, 1);
      for (int i = 0; i < 500; i++) cyc(0, 1, 0);

      // reset in the middle of line 7
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         if (mv == 7 && mh == 11) found = 1'b1;
         else cyc(0, 1, 0);
      end
      if (!found) check_val("reach_line7", 32'(0), 32'(1));
      hend = CW'(15);
      cyc(1, 1, 0);
      for (int i = 0; i < 300; i++) cyc(0, 1, 0);

      // randomized enables, loads, timing, compare line and resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99, 0) == 0) rand_timing();
         if ($urandom_range(49, 0) == 0) lcmp = CW'($urandom_range(12, 0));
         cyc($urandom_range(999, 0) == 0, $urandom_range(3, 0) != 0,
             $urandom_range(59, 0) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
